// File: rtl/logic_gate_sweeper.sv
`default_nettype none
// ============================================================================
// logic_gate_sweeper : N-input universal gate with truth-table sweep engine
// Rev 1.0
// ============================================================================
module logic_gate_sweeper #(
   parameter int N_IN = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           mode,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic [N_IN-1:0]      row_in,
   output logic                 row_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   truth_table,
   output logic [N_IN:0]        ones_count
);

   localparam int              ROWS     = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_ROW = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q;
   logic [N_IN-1:0] counter_q;
   logic [2:0]      mode_q;
   logic [ROWS-1:0] truth_q;
   logic [N_IN:0]   ones_q;
   logic            valid_q;
   logic            busy_q;
   logic            done_q;
   logic            gate_d;

   // Gate result for the current row; BUF/NOT look at bit 0 only.
   always_comb begin
      gate_d = 1'b0;
      case (mode_q)
         3'd0:    gate_d = &counter_q;
         3'd1:    gate_d = |counter_q;
         3'd2:    gate_d = ~&counter_q;
         3'd3:    gate_d = ~|counter_q;
         3'd4:    gate_d = ^counter_q;
         3'd5:    gate_d = ~^counter_q;
         3'd6:    gate_d = counter_q[0];
         default: gate_d = ~counter_q[0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         counter_q <= '0;
         mode_q    <= '0;
         truth_q   <= '0;
         ones_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  counter_q <= '0;
                  truth_q   <= '0;
                  ones_q    <= '0;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               if (row_ready) begin
                  truth_q[counter_q] <= gate_d;
                  ones_q             <= ones_q + (N_IN+1)'(gate_d);
                  // The counter parks on the last row until the next start.
                  if (counter_q == LAST_ROW) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     counter_q <= counter_q + N_IN'(1);
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign row_valid   = valid_q;
   assign row_in      = counter_q;
   assign row_out     = gate_d;
   assign busy        = busy_q;
   assign done        = done_q;
   assign truth_table = truth_q;
   assign ones_count  = ones_q;

endmodule
`default_nettype wire
